// File: rtl/sort_stream_unit.sv
// sort_stream_unit
//   Serial-in / serial-out sorter. Collects NUM signed DW-bit words, sorts them
//   ascending with an odd-even transposition network (one pass per cycle), then
//   streams NUM results according to the mode latched with the first word:
//     mode 0: ascending, 1: descending, 2: circular adjacent sums,
//     mode 3: adjacent differences, with the range (max - min) as the last result.
//
// Ports
//   clk         in   1      clock, rising edge
//   rst_n       in   1      asynchronous reset, active low
//   in_valid    in   1      in_number/mode valid this cycle
//   in_number   in   DW     signed input word
//   mode        in   2      operation select, sampled with the first word of a batch
//   in_ready    out  1      input accepted this cycle (IDLE/COLLECT only)
//   out_ready   in   1      downstream accepts out_result this cycle
//   out_valid   out  1      out_result valid
//   out_result  out  DW+2   signed result, sign-extended; zero while out_valid is low
//
// State     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for the first word of a batch; cnt_q = 0
// S_COLLECT | storing words; cnt_q = number of words stored so far
// S_SORT    | one transposition pass per cycle; cnt_q = pass number
// S_OUT     | streaming results; cnt_q = output index of the word on out_result

module sort_stream_unit #(
    parameter int NUM = 4,
    parameter int DW  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_number,
    input  logic [1:0]        mode,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DW+1:0]     out_result
);

    localparam int CW = $clog2(NUM);
    localparam int RW = DW + 2;
    localparam logic [CW-1:0] LAST = CW'(NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_SORT,
        S_OUT
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            mode_q, mode_d;
    logic signed [DW-1:0]  buf_q [NUM];
    logic signed [DW-1:0]  buf_d [NUM];
    logic                  out_valid_q, out_valid_d;
    logic [RW-1:0]         out_result_q, out_result_d;

    logic                  accept;
    logic signed [DW-1:0]  srt [NUM];
    logic [CW-1:0]         sel, sel_nxt;
    logic                  sel_last;
    logic signed [RW-1:0]  a_cur, a_nxt, a_rev;
    logic [RW-1:0]         res;

    function automatic logic signed [RW-1:0] sext(input logic signed [DW-1:0] v);
        return {{2{v[DW-1]}}, v};
    endfunction

    assign in_ready   = (state_q == S_IDLE) || (state_q == S_COLLECT);
    assign accept     = in_valid && in_ready;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;

    // One transposition pass; pass parity selects which neighbour pairs compare.
    // The pairs within a pass are disjoint, so swapping in place is safe.
    always_comb begin
        srt = buf_q;
        for (int i = 0; i < NUM - 1; i++) begin
            if ((i % 2) == int'(cnt_q[0])) begin
                if (srt[i] > srt[i+1]) begin
                    srt[i]   = buf_q[i+1];
                    srt[i+1] = buf_q[i];
                end
            end
        end
    end

    // Result for the index that will sit on out_result after the next edge:
    // the current index when first entering OUT, the following one afterwards.
    always_comb begin
        sel      = out_valid_q ? cnt_q + 1'b1 : cnt_q;
        sel_last = (sel == LAST);
        sel_nxt  = sel_last ? '0 : sel + 1'b1;
        a_cur    = sext(buf_q[sel]);
        a_nxt    = sext(buf_q[sel_nxt]);
        a_rev    = sext(buf_q[LAST - sel]);
        res      = '0;
        case (mode_q)
            2'd0: res = a_cur;
            2'd1: res = a_rev;
            2'd2: res = a_cur + a_nxt;
            // On the last index sel_nxt wraps to 0, so the range is a_cur - a_nxt.
            2'd3: res = sel_last ? (a_cur - a_nxt) : (a_nxt - a_cur);
            default: res = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        buf_d        = buf_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    buf_d[cnt_q] = in_number;
                    mode_d       = mode;
                    cnt_d        = cnt_q + 1'b1;
                    state_d      = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    buf_d[cnt_q] = in_number;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = S_SORT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_SORT: begin
                buf_d = srt;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_OUT: begin
                if (!out_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_result_d = res;
                end else if (out_ready) begin
                    if (cnt_q == LAST) begin
                        out_valid_d  = 1'b0;
                        out_result_d = '0;
                        cnt_d        = '0;
                        state_d      = S_IDLE;
                    end else begin
                        cnt_d        = cnt_q + 1'b1;
                        out_result_d = res;
                    end
                end
            end
            default: begin
                state_d      = S_IDLE;
                cnt_d        = '0;
                out_valid_d  = 1'b0;
                out_result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mode_q       <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            for (int i = 0; i < NUM; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            buf_q        <= buf_d;
        end
    end

endmodule

// File: tb/tb_sort_stream_unit.sv
module tb_sort_stream_unit;

    localparam int NUM = 4;
    localparam int DW  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_number;
    logic [1:0]    mode;
    logic          in_ready;
    logic          out_ready;
    logic          out_valid;
    logic [DW+1:0] out_result;

    sort_stream_unit #(.NUM(NUM), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_number  (in_number),
        .mode       (mode),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_result (out_result)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int hs_count = 0;
    int exp_q[$];

    typedef struct {
        int w  [4];
        int md;
        int ex [4];
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: compare each handshaken result, check hold under backpressure
    // and the zero value while idle.
    logic          prev_v = 1'b0;
    logic          prev_r = 1'b0;
    logic [DW+1:0] prev_res = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (!out_valid) begin
                check("zero_when_invalid", int'(out_result), 0);
            end else begin
                if (prev_v && !prev_r)
                    check("held_result", int'(out_result), int'(prev_res));
                if (out_ready) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %0d, expected none",
                                 int'($signed(out_result)));
                    end else begin
                        check("result", int'($signed(out_result)), exp_q.pop_front());
                    end
                end
            end
            prev_v   = out_valid;
            prev_r   = out_ready;
            prev_res = out_result;
        end
    end

    task automatic set_vec(input int idx, input int w0, input int w1, input int w2,
                           input int w3, input int md, input int e0, input int e1,
                           input int e2, input int e3);
        vecs[idx].w[0] = w0; vecs[idx].w[1] = w1; vecs[idx].w[2] = w2; vecs[idx].w[3] = w3;
        vecs[idx].md = md;
        vecs[idx].ex[0] = e0; vecs[idx].ex[1] = e1; vecs[idx].ex[2] = e2; vecs[idx].ex[3] = e3;
    endtask

    task automatic send_word(input int v, input int md);
        int n;
        logic [31:0] vb;
        n  = 0;
        vb = v;
        in_valid  = 1'b1;
        in_number = vb[DW-1:0];
        mode      = md[1:0];
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("in_ready_timeout", n, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input int idx);
        for (int j = 0; j < 4; j++) exp_q.push_back(vecs[idx].ex[j]);
        for (int j = 0; j < 4; j++) send_word(vecs[idx].w[j], vecs[idx].md);
    endtask

    // Reference: plain bubble sort, then the mode's arithmetic.
    task automatic push_model(input int a0, input int a1, input int a2, input int a3,
                              input int md);
        int s [4];
        int t;
        s[0] = a0; s[1] = a1; s[2] = a2; s[3] = a3;
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 3; i++)
                if (s[i] > s[i+1]) begin
                    t = s[i]; s[i] = s[i+1]; s[i+1] = t;
                end
        for (int k = 0; k < 4; k++) begin
            case (md)
                0: exp_q.push_back(s[k]);
                1: exp_q.push_back(s[3-k]);
                2: exp_q.push_back(s[k] + s[(k+1)%4]);
                default: exp_q.push_back((k < 3) ? s[k+1] - s[k] : s[3] - s[0]);
            endcase
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        check("idle_in_ready", int'(in_ready), 1);
        check("idle_out_valid", int'(out_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hs0;
        int r [4];
        int pat [7];

        rst_n = 1'b0; in_valid = 1'b0; in_number = '0; mode = '0; out_ready = 1'b1;
        #3;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_result", int'(out_result), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        set_vec(0,  3, -2,  7, -8, 0,  -8,  -2,   3,   7);
        set_vec(1,  3, -2,  7, -8, 1,   7,   3,  -2,  -8);
        set_vec(2,  3, -2,  7, -8, 2, -10,   1,  10,  -1);
        set_vec(3,  3, -2,  7, -8, 3,   6,   5,   4,  15);
        set_vec(4, -8, -8, -8, -8, 2, -16, -16, -16, -16);
        set_vec(5,  7, -8,  7, -8, 3,   0,  15,   0,  15);
        set_vec(6,  1,  1,  0, -1, 0,  -1,   0,   1,   1);

        // Latency: last word accepted at edge T, out_valid high after edge T+NUM+1.
        for (int j = 0; j < 4; j++) exp_q.push_back(vecs[0].ex[j]);
        for (int j = 0; j < 3; j++) send_word(vecs[0].w[j], vecs[0].md);
        in_valid = 1'b1; in_number = 4'b1000; mode = 2'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, NUM + 1);
        wait_drain();

        for (int v = 1; v < 7; v++) begin
            send_vec(v);
            wait_drain();
        end

        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 4; j++) r[j] = int'($urandom_range(15)) - 8;
            push_model(r[0], r[1], r[2], r[3], b);
            for (int j = 0; j < 4; j++) send_word(r[j], b);
            wait_drain();
        end

        // Gaps in in_valid, mode changing after the first word, input ignored while busy.
        exp_q.push_back(5); exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(-3);
        in_valid = 1'b1; in_number = 4'd5;     mode = 2'd1; @(posedge clk); #1;
        in_valid = 1'b0;                       mode = 2'd3; @(posedge clk); #1;
        in_valid = 1'b1; in_number = 4'b1101;  mode = 2'd3; @(posedge clk); #1;
        in_valid = 1'b1; in_number = 4'd0;     mode = 2'd2; @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1; in_number = 4'd2;     mode = 2'd0; @(posedge clk); #1;
        in_number = 4'd7;
        for (int c = 0; c < 8; c++) begin
            check("busy_in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_drain();

        // Backpressure.
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1; pat[6] = 1;
        for (int j = 0; j < 4; j++) exp_q.push_back(vecs[0].ex[j]);
        out_ready = 1'b0;
        for (int j = 0; j < 4; j++) send_word(vecs[0].w[j], vecs[0].md);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_valid_seen", int'(out_valid), 1);
        hs0 = hs_count;
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i][0];
            @(posedge clk); #1;
        end
        check("bp_handshakes", hs_count - hs0, 4);
        check("bp_in_ready", int'(in_ready), 1);
        check("bp_out_valid", int'(out_valid), 0);
        check("bp_queue_empty", exp_q.size(), 0);
        out_ready = 1'b1;
        exp_q.delete();

        // Reset in the middle of OUT after two results.
        for (int j = 0; j < 4; j++) exp_q.push_back(vecs[0].ex[j]);
        for (int j = 0; j < 4; j++) send_word(vecs[0].w[j], vecs[0].md);
        n = 0;
        while (exp_q.size() > 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_mid_two_results", exp_q.size(), 2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", int'(out_valid), 0);
        check("rst_mid_out_result", int'(out_result), 0);
        check("rst_mid_in_ready", int'(in_ready), 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send_vec(6);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
